// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker: sweeps all 2^N_IN input vectors onto a DUT and
// compares its response against a loadable golden table, delayed by RESP_LAT.
module truth_table_checker #(
  parameter int unsigned N_IN     = 3,
  parameter int unsigned RESP_LAT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [(1 << N_IN)-1:0]   cfg_data,
  input  logic                     start,
  output logic [N_IN-1:0]          stim,
  output logic                     stim_valid,
  input  logic                     resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [N_IN:0]            err_cnt,
  output logic [N_IN-1:0]          first_err_idx,
  output logic                     first_err_vld
);

  localparam int unsigned DEPTH = 1 << N_IN;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [N_IN-1:0] IDX_MAX  = '1;
  localparam logic [N_IN-1:0] IDX_ONE  = 1;
  localparam logic [N_IN:0]   CNT_ONE  = 1;

  logic [1:0]        r_state;
  logic [DEPTH-1:0]  r_table;
  logic [N_IN-1:0]   r_stim;
  logic              r_stim_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [N_IN:0]     r_err_cnt;
  logic [N_IN-1:0]   r_first_err_idx;
  logic              r_first_err_vld;
  logic              r_cfg_ready;
  logic [N_IN-1:0]   r_cmp_idx;

  logic              w_exp_now;
  logic              w_exp;
  logic              w_cmp_vld;
  logic              w_mis;
  logic              w_load;

  assign w_exp_now = r_table[r_stim];
  assign w_load    = cfg_valid && r_cfg_ready;

  // Expected bit travels alongside the DUT's own latency so compares line up.
  generate
    if (RESP_LAT == 0) begin : g_lat0
      assign w_exp     = w_exp_now;
      assign w_cmp_vld = r_stim_valid;
    end else begin : g_latn
      logic [RESP_LAT-1:0] r_exp_pipe;
      logic [RESP_LAT-1:0] r_vld_pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_exp_pipe <= '0;
          r_vld_pipe <= '0;
        end else begin
          r_exp_pipe[0] <= w_exp_now;
          r_vld_pipe[0] <= r_stim_valid;
          for (int unsigned i = 1; i < RESP_LAT; i++) begin
            r_exp_pipe[i] <= r_exp_pipe[i-1];
            r_vld_pipe[i] <= r_vld_pipe[i-1];
          end
        end
      end

      assign w_exp     = r_exp_pipe[RESP_LAT-1];
      assign w_cmp_vld = r_vld_pipe[RESP_LAT-1];
    end
  endgenerate

  assign w_mis = w_cmp_vld && (resp != w_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_table         <= '0;
      r_stim          <= '0;
      r_stim_valid    <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_err_cnt       <= '0;
      r_first_err_idx <= '0;
      r_first_err_vld <= 1'b0;
      r_cfg_ready     <= 1'b1;
      r_cmp_idx       <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // A table load in the same cycle as start takes priority.
          if (w_load) begin
            r_table <= cfg_data;
          end else if (start) begin
            r_state         <= ST_SWEEP;
            r_cfg_ready     <= 1'b0;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_first_err_vld <= 1'b0;
            r_stim          <= '0;
            r_stim_valid    <= 1'b1;
            r_cmp_idx       <= '0;
          end
        end
        ST_SWEEP: begin
          if (r_stim_valid) begin
            if (r_stim == IDX_MAX) begin
              r_stim_valid <= 1'b0;
            end else begin
              r_stim <= r_stim + IDX_ONE;
            end
          end
          if (w_cmp_vld) begin
            r_cmp_idx <= r_cmp_idx + IDX_ONE;
            if (w_mis) begin
              r_err_cnt <= r_err_cnt + CNT_ONE;
              if (!r_first_err_vld) begin
                r_first_err_idx <= r_cmp_idx;
                r_first_err_vld <= 1'b1;
              end
            end
            // The verdict must include the compare happening on this same edge.
            if (r_cmp_idx == IDX_MAX) begin
              r_state     <= ST_DONE;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_cfg_ready <= 1'b1;
              r_pass      <= (r_err_cnt == '0) && !w_mis;
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign cfg_ready     = r_cfg_ready;
  assign stim          = r_stim;
  assign stim_valid    = r_stim_valid;
  assign busy          = r_busy;
  assign done          = r_done;
  assign pass          = r_pass;
  assign err_cnt       = r_err_cnt;
  assign first_err_idx = r_first_err_idx;
  assign first_err_vld = r_first_err_vld;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker: a RESP_LAT=0 and a RESP_LAT=2 instance
// share control inputs; each has its own behavioural DUT response model.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       start;

  logic       cfg_ready0, stim_valid0, busy0, done0, pass0, fvld0, resp0;
  logic [2:0] stim0, fidx0;
  logic [3:0] err0;

  logic       cfg_ready2, stim_valid2, busy2, done2, pass2, fvld2, resp2;
  logic [2:0] stim2, fidx2;
  logic [3:0] err2;

  int unsigned mode0;
  logic        d0_1, d0_2, d2_1, d2_2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.N_IN(3), .RESP_LAT(0)) u_lat0 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready0),
    .cfg_data(cfg_data), .start(start), .stim(stim0), .stim_valid(stim_valid0),
    .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .first_err_idx(fidx0), .first_err_vld(fvld0)
  );

  truth_table_checker #(.N_IN(3), .RESP_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
    .cfg_data(cfg_data), .start(start), .stim(stim2), .stim_valid(stim_valid2),
    .resp(resp2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2),
    .first_err_idx(fidx2), .first_err_vld(fvld2)
  );

  // Modelled DUT: 3-input XOR, optionally faulted or delayed by two registers.
  always_ff @(posedge clk) begin
    d0_1 <= ^stim0;
    d0_2 <= d0_1;
    d2_1 <= ^stim2;
    d2_2 <= d2_1;
  end

  always_comb begin
    resp0 = ^stim0;
    case (mode0)
      1: resp0 = (^stim0) ^ (stim0 == 3'd5);
      2: resp0 = ~(^stim0);
      3: resp0 = d0_2;
      default: resp0 = ^stim0;
    endcase
  end
  assign resp2 = d2_2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_both_done();
    for (int i = 0; i < 40; i++) begin
      if (done0 && done2) break;
      tick();
    end
    chk("sweep_timeout", {30'd0, done0, done2}, 32'd3);
  endtask

  task automatic run_sweep();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_both_done();
  endtask

  int n;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = 8'h00; start = 1'b0; mode0 = 0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_stim",       stim0, 0);
    chk("rst_stim_valid", stim_valid0, 0);
    chk("rst_busy",       busy0, 0);
    chk("rst_done",       done0, 0);
    chk("rst_pass",       pass0, 0);
    chk("rst_err_cnt",    err0, 0);
    chk("rst_fvld",       fvld0, 0);
    chk("rst_cfg_ready",  cfg_ready0, 1);

    // Parity table, matching XOR DUT.
    cfg_valid = 1'b1; cfg_data = 8'b1001_0110;
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy",       busy0, 1);
    chk("t1_stim_valid", stim_valid0, 1);
    for (int k = 0; k < 8; k++) begin
      chk("t1_stim_seq", stim0, k);
      tick();
    end
    chk("t1_done",         done0, 1);
    chk("t1_pass",         pass0, 1);
    chk("t1_err_cnt",      err0, 0);
    chk("t1_fvld",         fvld0, 0);
    chk("t1_stim_hold",    stim0, 7);
    chk("t1_stim_vld_off", stim_valid0, 0);
    chk("t1_busy_off",     busy0, 0);
    chk("lat2_not_done9",  done2, 0);
    tick();
    chk("lat2_not_done10", done2, 0);
    tick();
    chk("lat2_done11",     done2, 1);
    chk("lat2_pass",       pass2, 1);

    // Single fault at index 5.
    mode0 = 1;
    run_sweep();
    chk("t2_err_cnt", err0, 1);
    chk("t2_fidx",    fidx0, 5);
    chk("t2_fvld",    fvld0, 1);
    chk("t2_pass",    pass0, 0);

    // Two-cycle-latency DUT checked with zero latency must fail.
    mode0 = 3;
    run_sweep();
    chk("t3_lat_mismatch_pass", pass0, 0);
    chk("t3_lat2_pass",         pass2, 1);

    // Every response wrong.
    mode0 = 2;
    run_sweep();
    chk("t4_err_cnt", err0, 8);
    chk("t4_fidx",    fidx0, 0);
    chk("t4_fvld",    fvld0, 1);
    chk("t4_pass",    pass0, 0);

    // Load and start attempts during SWEEP are ignored.
    mode0 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'h00; start = 1'b1;
    chk("t5_cfg_ready_sweep", cfg_ready0, 0);
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    n = 2;
    while (!done0 && n < 40) begin
      tick();
      n++;
    end
    chk("t5_no_restart_latency", n, 9);
    chk("t5_pass_table_kept",    pass0, 1);
    chk("t5_err_cnt",            err0, 0);
    tick(); tick();

    // Reset mid-sweep clears everything, table included.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_stim_before_rst", stim0, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_stim",       stim0, 0);
    chk("t6_stim_valid", stim_valid0, 0);
    chk("t6_busy",       busy0, 0);
    chk("t6_done",       done0, 0);
    chk("t6_err_cnt",    err0, 0);
    chk("t6_fvld",       fvld0, 0);
    chk("t6_cfg_ready",  cfg_ready0, 1);
    run_sweep();
    chk("t6_zero_table_err", err0, 4);
    chk("t6_zero_table_fidx", fidx0, 1);
    chk("t6_zero_table_pass", pass0, 0);

    // start together with cfg_valid in IDLE: load only.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'b1001_0110; start = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b0;
    chk("t7_busy_stays_low",  busy0, 0);
    chk("t7_stim_valid_low",  stim_valid0, 0);
    tick();
    chk("t7_busy_still_low",  busy0, 0);
    run_sweep();
    chk("t7_table_loaded_pass", pass0, 1);
    chk("t7_err_cnt",           err0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
Parametrised, self-running exhaustive checker for small combinational or pipelined logic functions. It holds a loadable golden truth table of 2^N_IN entries, drives every input combination in ascending order onto a device under test, compares the returned response against the table, and reports a pass/fail verdict, an error count and the first failing index. It sits beside a logic block as on-chip or bench-level verification infrastructure, replacing hand-written input sweeps.

Parameters:
N_IN, 3, number of DUT inputs; legal range 1..10; table depth is 2^N_IN.
RESP_LAT, 0, DUT response latency in clk cycles; legal range 0..8.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
cfg_valid  input  1  table load request.
cfg_ready  output  1  table load accepted when high with cfg_valid.
cfg_data  input  2^N_IN  golden table; bit i is the expected output for input index i.
start  input  1  single-cycle sweep request.
stim  output  N_IN  stimulus to DUT; bit N_IN-1 is MSB (x for N_IN=3).
stim_valid  output  1  stim is a live sweep vector.
resp  input  1  DUT output.
busy  output  1  high while in SWEEP.
done  output  1  high while in DONE.
pass  output  1  valid when done; 1 iff err_cnt==0.
err_cnt  output  N_IN+1  mismatch count; holds up to 2^N_IN without saturation.
first_err_idx  output  N_IN  index of the first mismatch.
first_err_vld  output  1  first_err_idx is meaningful.

Behaviour:
- Reset: state IDLE; table=0; stim=0, stim_valid=0, busy=0, done=0, pass=0, err_cnt=0, first_err_idx=0, first_err_vld=0. Reset mid-sweep aborts immediately, with the same values applied on the next edge.
- FSM: IDLE -> SWEEP on start; SWEEP -> DONE after the last compare; DONE -> SWEEP on start. No other transitions except reset.
- cfg_ready=1 in IDLE and DONE, and 0 in SWEEP. On cfg_valid&&cfg_ready the table is written at the edge. Load does not change state or clear results.
- start and cfg_valid in the same IDLE/DONE cycle: load wins and start is ignored.
- start in SWEEP is ignored.
- Start sampled at edge t: at t+1 the block enters SWEEP, clears err_cnt, first_err_idx, first_err_vld and pass, and sets stim=0, stim_valid=1.
- stim increments by 1 each cycle through 2^N_IN-1. At the next cycle stim_valid drops and stim holds its last value.
- Expected-bit pipeline: table[stim] and a valid flag are delayed RESP_LAT stages. With RESP_LAT=0, resp is compared in the same cycle stim is presented.
- Compare for index k occurs at cycle t+1+k+RESP_LAT. On mismatch, err_cnt increments. If first_err_vld=0, first_err_idx<=k and first_err_vld<=1.
- DONE entered at t+1+2^N_IN+RESP_LAT. On entry: busy=0, done=1, pass=(err_cnt==0) including the final compare. Results hold until the next start or rst.
- All outputs are registered. The table is static during SWEEP.

Test Plan:
- N_IN=3, RESP_LAT=0: load cfg_data=8'b1001_0110 and model resp as XOR of stim bits; start at t -> stim 0..7 on t+1..t+8, done=1 at t+9, pass=1, err_cnt=0, first_err_vld=0.
- Same setup with resp inverted only when stim==5 -> err_cnt=1, first_err_idx=5, first_err_vld=1, pass=0.
- RESP_LAT=2 with a DUT model delayed by two registers -> pass=1, done at t+11. Same DUT with RESP_LAT=0 -> pass=0.
- From DONE, restart with resp forced to ~expected -> err_cnt=8, first_err_idx=0. cfg_valid during SWEEP -> cfg_ready=0 and table unchanged. start during SWEEP -> no restart.
- rst asserted while stim==4 -> next cycle all outputs 0, IDLE state, table=0. start and cfg_valid together in IDLE -> table loaded and busy stays 0.
